// File: rtl/lcd_pkg.sv
// Shared constants, arbiter state encoding and helpers for the LCD text path.
// Imported by lcd_rr_pick and lcd_text_arbiter.
package lcd_pkg;

   // Characters per LCD message (two 16-char lines plus separators).
   localparam int TEXT_LENGTH    = 34;

   // System clock frequency in Hz.
   localparam int FREQ           = 50_000_000;

   // Watchdog window for one LCD transfer, in milliseconds and cycles.
   localparam int TIMEOUT_MS     = 100;
   localparam int TIMEOUT_CYCLES = (FREQ / 1000) * TIMEOUT_MS;

   // Width of requester indices (covers up to 8 requesters).
   localparam int IDX_W          = 3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_LOW  = 3'd2,
      ST_WAIT_HIGH = 3'd3,
      ST_DONE      = 3'd4
   } arb_state_t;

   // Successor of idx in a ring of n requesters.
   function automatic logic [IDX_W-1:0] next_idx(
      input logic [IDX_W-1:0] idx,
      input int               n
   );
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/lcd_rr_pick.sv
// Round-robin selector: first pending index at or after rr_ptr, wrapping.
// Ports: pending (request vector), rr_ptr (search start), grant, any_valid.
module lcd_rr_pick
   import lcd_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] pending,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [IDX_W-1:0]   grant,
   output logic               any_valid
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   int j;

   // Scan NUM_REQ positions starting at rr_ptr; the first hit wins.
   always_comb begin
      grant     = '0;
      any_valid = 1'b0;
      j         = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         if (!any_valid && pending[j[IW-1:0]]) begin
            grant     = IDX_W'(j);
            any_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter granting NUM_REQ text requesters access to one LCD
// text sender. Optional watchdog: define LCD_ARB_TIMEOUT_EN.
// Ports:
//   CLK, RST_N        clock, async active-low reset
//   req, text_in      request pulses and packed per-requester texts
//   done              per-requester completion pulse
//   busy, gnt_idx     service in progress and serviced requester
//   lcd_send_text     start pulse to the sender
//   lcd_text          message latched at grant
//   lcd_sending_done  level completion flag from the sender
//   timeout_err       watchdog expiry pulse (0 when compiled out)
module lcd_text_arbiter
   import lcd_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TEXT_LENGTH    = lcd_pkg::TEXT_LENGTH,
   parameter int TIMEOUT_CYCLES = lcd_pkg::TIMEOUT_CYCLES
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ*8*TEXT_LENGTH-1:0] text_in,
   output logic [NUM_REQ-1:0]              done,
   output logic                            busy,
   output logic [2:0]                      gnt_idx,
   output logic                            lcd_send_text,
   output logic [8*TEXT_LENGTH-1:0]        lcd_text,
   input  logic                            lcd_sending_done,
   output logic                            timeout_err
);

   localparam int TW = 8 * TEXT_LENGTH;

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
      $error("lcd_text_arbiter: NUM_REQ must be 2..8");
   end

   if (TIMEOUT_CYCLES < 1) begin : g_bad_to
      $error("lcd_text_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   arb_state_t         state;
   logic [NUM_REQ-1:0] pending;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   pick;
   logic               any_valid;
   logic [NUM_REQ-1:0] clr;
   logic [NUM_REQ-1:0] gnt_hot;
   logic [TW-1:0]      pick_text;
   logic               expired;

   lcd_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .pending   (pending),
      .rr_ptr    (rr_ptr),
      .grant     (pick),
      .any_valid (any_valid)
   );

   assign pick_text = text_in[TW*int'(pick) +: TW];

   // clr: bit being granted this cycle; gnt_hot: decoded current grant.
   always_comb begin
      clr     = '0;
      gnt_hot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         clr[i]     = (state == ST_IDLE) && any_valid
                      && (pick == IDX_W'(i));
         gnt_hot[i] = (gnt_idx == IDX_W'(i));
      end
   end

`ifdef LCD_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd;
   logic            in_wait;

   assign in_wait = (state == ST_WAIT_LOW) || (state == ST_WAIT_HIGH);

   // wd holds the number of wait cycles already spent before this one.
   assign expired = in_wait && (wd == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         wd          <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= expired;
         if ((state == ST_IDLE) && any_valid) begin
            wd <= '0;
         end else if (in_wait && !expired) begin
            wd <= wd + 1'b1;
         end
      end
   end
`else
   assign expired     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= ST_IDLE;
         pending       <= '0;
         rr_ptr        <= '0;
         gnt_idx       <= '0;
         lcd_text      <= '0;
         done          <= '0;
         busy          <= 1'b0;
         lcd_send_text <= 1'b0;
      end else begin
         // A new request beats the grant-clear of the same bit.
         pending       <= (pending & ~clr) | req;
         done          <= '0;
         lcd_send_text <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (any_valid) begin
                  state         <= ST_SEND;
                  gnt_idx       <= pick;
                  lcd_text      <= pick_text;
                  busy          <= 1'b1;
                  lcd_send_text <= 1'b1;
               end
            end
            ST_SEND: begin
               state <= ST_WAIT_LOW;
            end
            // A high flag left over from the last message is not
            // completion; wait for it to drop first.
            ST_WAIT_LOW: begin
               if (expired) begin
                  state <= ST_DONE;
                  done  <= gnt_hot;
               end else if (!lcd_sending_done) begin
                  state <= ST_WAIT_HIGH;
               end
            end
            ST_WAIT_HIGH: begin
               if (expired || lcd_sending_done) begin
                  state <= ST_DONE;
                  done  <= gnt_hot;
               end
            end
            ST_DONE: begin
               rr_ptr <= next_idx(gnt_idx, NUM_REQ);
               state  <= ST_IDLE;
               busy   <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
